// File: rtl/sram_bank_arbiter_if.sv
// sram_bank_arbiter_if: requester-side and SRAM-bank-side bus bundle for sram_bank_arbiter
// Requester side: req_valid/req_ready/req_wr/req_lock (bit n = requester n), req_addr0/1,
//   req_wdata0/1, req_wstrb0/1, rsp_valid, rsp_rdata0/1.
// Bank side: sram_addr_bank0/1, bank0_csn/bank1_csn (active low), wen (active low, per bank),
//   sram_wdata (shared), sram0..sram7 lane read data (bank0 = sram0..3, bank1 = sram4..7).
// slave = arbiter view, master = requesters plus SRAM array view.
interface sram_bank_arbiter_if #(
    parameter int IDX_W  = 13,
    parameter int ADDR_W = 14
);
    logic [1:0]        req_valid, req_ready, req_wr, req_lock, rsp_valid, wen;
    logic [ADDR_W-1:0] req_addr0, req_addr1;
    logic [31:0]       req_wdata0, req_wdata1, rsp_rdata0, rsp_rdata1, sram_wdata;
    logic [3:0]        req_wstrb0, req_wstrb1, bank0_csn, bank1_csn;
    logic [IDX_W-1:0]  sram_addr_bank0, sram_addr_bank1;
    logic [7:0]        sram0, sram1, sram2, sram3, sram4, sram5, sram6, sram7;

    modport slave (
        input  req_valid, req_wr, req_lock, req_addr0, req_addr1, req_wdata0, req_wdata1,
               req_wstrb0, req_wstrb1, sram0, sram1, sram2, sram3, sram4, sram5, sram6, sram7,
        output req_ready, rsp_valid, rsp_rdata0, rsp_rdata1, sram_addr_bank0, sram_addr_bank1,
               bank0_csn, bank1_csn, wen, sram_wdata
    );

    modport master (
        output req_valid, req_wr, req_lock, req_addr0, req_addr1, req_wdata0, req_wdata1,
               req_wstrb0, req_wstrb1, sram0, sram1, sram2, sram3, sram4, sram5, sram6, sram7,
        input  req_ready, rsp_valid, rsp_rdata0, rsp_rdata1, sram_addr_bank0, sram_addr_bank1,
               bank0_csn, bank1_csn, wen, sram_wdata
    );
endinterface

// File: rtl/sram_bank_arbiter.sv
// sram_bank_arbiter: two-requester arbiter in front of a dual-bank, byte-lane SRAM array
// Ports: ACLK clock; ARESETn async active-low reset; bus (sram_bank_arbiter_if.slave) carries
//   the requester handshake, read responses and the bank strobes/lane read data.
// Requesters on different banks with at most one write are granted together; otherwise a
// round-robin pointer picks one and flips. Read data returns one cycle after grant.
// Optional: define SRAM_ARB_LOCK_EN to enable the req_lock exclusive hold.
module sram_bank_arbiter #(
    parameter int IDX_W  = 13,
    parameter int ADDR_W = 14
) (
    input logic                ACLK,
    input logic                ARESETn,
    sram_bank_arbiter_if.slave bus
);
    if (ADDR_W != IDX_W + 1) begin : g_bad_width
        $error("ADDR_W must be IDX_W + 1");
    end

    logic        rr_q, rr_d;
    logic [1:0]  pend_q, pend_d, tbank_q, tbank_d;
    logic [1:0]  bank, grant, use0, use1;
    logic        conflict;
    logic [31:0] lanes0, lanes1;

    assign lanes0 = {bus.sram3, bus.sram2, bus.sram1, bus.sram0};
    assign lanes1 = {bus.sram7, bus.sram6, bus.sram5, bus.sram4};

`ifdef SRAM_ARB_LOCK_EN
    logic lock_q, lock_d, own_q, own_d;
`else
    logic unused_lock;
    assign unused_lock = ^bus.req_lock;
`endif

    always_comb begin
        bank     = {bus.req_addr1[IDX_W], bus.req_addr0[IDX_W]};
        conflict = (&bus.req_valid) && ((bank[0] == bank[1]) || (&bus.req_wr));
        grant    = conflict ? (rr_q ? 2'b10 : 2'b01) : bus.req_valid;
        rr_d     = conflict ? ~rr_q : rr_q;
`ifdef SRAM_ARB_LOCK_EN
        lock_d   = lock_q;
        own_d    = own_q;
        if (lock_q) begin
            // Owner is served whenever valid; dropping req_lock releases whether or not it is valid.
            grant  = bus.req_valid & (own_q ? 2'b10 : 2'b01);
            rr_d   = rr_q;
            lock_d = bus.req_lock[own_q];
        end else if (|(grant & bus.req_lock)) begin
            lock_d = 1'b1;
            own_d  = ~(grant[0] & bus.req_lock[0]);
        end
`endif
        // Outputs are forced idle for the whole time reset is asserted.
        grant    = ARESETn ? grant : 2'b00;
        // use<n>[b]: requester n is granted onto bank b
        use0     = grant[0] ? (bank[0] ? 2'b10 : 2'b01) : 2'b00;
        use1     = grant[1] ? (bank[1] ? 2'b10 : 2'b01) : 2'b00;
        pend_d   = grant & ~bus.req_wr;
        tbank_d  = bank;
        bus.req_ready       = grant;
        bus.sram_addr_bank0 = use0[0] ? bus.req_addr0[IDX_W-1:0] : (use1[0] ? bus.req_addr1[IDX_W-1:0] : '0);
        bus.sram_addr_bank1 = use0[1] ? bus.req_addr0[IDX_W-1:0] : (use1[1] ? bus.req_addr1[IDX_W-1:0] : '0);
        bus.bank0_csn       = use0[0] ? (bus.req_wr[0] ? ~bus.req_wstrb0 : 4'h0)
                            : (use1[0] ? (bus.req_wr[1] ? ~bus.req_wstrb1 : 4'h0) : 4'hF);
        bus.bank1_csn       = use0[1] ? (bus.req_wr[0] ? ~bus.req_wstrb0 : 4'h0)
                            : (use1[1] ? (bus.req_wr[1] ? ~bus.req_wstrb1 : 4'h0) : 4'hF);
        bus.wen             = ~((use0 & {2{bus.req_wr[0]}}) | (use1 & {2{bus.req_wr[1]}}));
        // Two writes always conflict, so at most one write is granted per cycle.
        bus.sram_wdata      = (grant[0] & bus.req_wr[0]) ? bus.req_wdata0
                            : ((grant[1] & bus.req_wr[1]) ? bus.req_wdata1 : '0);
        bus.rsp_valid       = pend_q;
        bus.rsp_rdata0      = pend_q[0] ? (tbank_q[0] ? lanes1 : lanes0) : '0;
        bus.rsp_rdata1      = pend_q[1] ? (tbank_q[1] ? lanes1 : lanes0) : '0;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rr_q    <= 1'b0;
            pend_q  <= 2'b00;
            tbank_q <= 2'b00;
        end else begin
            rr_q    <= rr_d;
            pend_q  <= pend_d;
            tbank_q <= tbank_d;
        end
    end

`ifdef SRAM_ARB_LOCK_EN
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            lock_q <= 1'b0;
            own_q  <= 1'b0;
        end else begin
            lock_q <= lock_d;
            own_q  <= own_d;
        end
    end
`endif
endmodule

// File: tb/tb_sram_bank_arbiter.sv
// tb_sram_bank_arbiter: directed scoreboard bench for sram_bank_arbiter with a behavioural SRAM array
module tb_sram_bank_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sram_bank_arbiter_if #(.IDX_W(13), .ADDR_W(14)) bus ();
    sram_bank_arbiter #(.IDX_W(13), .ADDR_W(14)) dut (.ACLK(clk), .ARESETn(rst_n), .bus(bus));

    typedef struct packed {
        logic [31:0] data;
        int          at;
    } exp_t;

    exp_t q0[$], q1[$];
    int total = 0, bad = 0, cyc = 0;

    logic [31:0] mem0[8192], mem1[8192];
    bit   [8191:0] wf0, wf1;
    logic [31:0] rd0 = '0, rd1 = '0;

    assign {bus.sram3, bus.sram2, bus.sram1, bus.sram0} = rd0;
    assign {bus.sram7, bus.sram6, bus.sram5, bus.sram4} = rd1;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] csn);
        for (int l = 0; l < 4; l++) if (!csn[l]) old[8*l +: 8] = d[8*l +: 8];
        return old;
    endfunction

    // SRAM array: unwritten words read as {8'hB0|bank, index}; strobes captured mid-cycle, applied at the edge.
    initial begin
        logic [3:0]  c0, c1;
        logic [1:0]  we;
        logic [12:0] a0, a1;
        logic [31:0] wd, o0, o1;
        forever begin
            @(negedge clk);
            c0 = bus.bank0_csn; c1 = bus.bank1_csn; we = bus.wen;
            a0 = bus.sram_addr_bank0; a1 = bus.sram_addr_bank1; wd = bus.sram_wdata;
            @(posedge clk);
            cyc++;
            o0 = wf0[a0] ? mem0[a0] : (32'hB000_0000 | 32'(a0));
            o1 = wf1[a1] ? mem1[a1] : (32'hB100_0000 | 32'(a1));
            if (c0 != 4'hF) begin
                if (we[0]) rd0 = o0;
                else begin mem0[a0] = merge(o0, wd, c0); wf0[a0] = 1'b1; end
            end
            if (c1 != 4'hF) begin
                if (we[1]) rd1 = o1;
                else begin mem1[a1] = merge(o1, wd, c1); wf1[a1] = 1'b1; end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, want);
        end
    endtask

    task automatic expect_rsp(input int n, input logic [31:0] d);
        exp_t e;
        e.data = d;
        e.at   = cyc + 1;
        if (n == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic pop_chk(input int n);
        exp_t e;
        logic [31:0] act;
        act = (n == 0) ? bus.rsp_rdata0 : bus.rsp_rdata1;
        if ((n == 0 && q0.size() == 0) || (n == 1 && q1.size() == 0)) begin
            total++;
            bad++;
            $display("FAIL rsp%0d_unexpected: got %h expected no response", n, act);
            return;
        end
        if (n == 0) e = q0.pop_front();
        else e = q1.pop_front();
        check($sformatf("rsp%0d_data", n), act, e.data);
        check($sformatf("rsp%0d_cycle", n), 32'(cyc), 32'(e.at));
    endtask

    initial forever begin
        @(negedge clk);
        if (bus.rsp_valid[0] === 1'b1) pop_chk(0);
        if (bus.rsp_valid[1] === 1'b1) pop_chk(1);
    end

    task automatic drive(input logic [1:0] v, input logic [1:0] wr, input logic [13:0] a0, input logic [13:0] a1,
                         input logic [31:0] w0, input logic [31:0] w1, input logic [3:0] s0, input logic [3:0] s1,
                         input logic [1:0] lk);
        @(posedge clk);
        #1;
        bus.req_valid = v; bus.req_wr = wr; bus.req_addr0 = a0; bus.req_addr1 = a1;
        bus.req_wdata0 = w0; bus.req_wdata1 = w1; bus.req_wstrb0 = s0; bus.req_wstrb1 = s1; bus.req_lock = lk;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(2'b00, 2'b00, 14'h0, 14'h0, 32'h0, 32'h0, 4'h0, 4'h0, 2'b00);
    endtask

    initial begin
        // Reset: outputs idle even with both requesters valid.
        drive(2'b11, 2'b00, 14'h0010, 14'h2010, 32'h0, 32'h0, 4'h0, 4'h0, 2'b00);
        check("rst_ready", 32'(bus.req_ready), 32'h0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("rst_rdata0", bus.rsp_rdata0, 32'h0);
        check("rst_csn", {24'h0, bus.bank1_csn, bus.bank0_csn}, 32'hFF);
        check("rst_wen", 32'(bus.wen), 32'h3);
        check("rst_wdata", bus.sram_wdata, 32'h0);
        check("rst_addr", {6'h0, bus.sram_addr_bank1, bus.sram_addr_bank0}, 32'h0);
        bus.req_valid = 2'b00;
        rst_n = 1'b1;

        // Parallel: read bank0 and write bank1 together.
        drive(2'b11, 2'b10, 14'h0010, 14'h2010, 32'h0, 32'hA5A5_5A5A, 4'h0, 4'hF, 2'b00);
        check("par_ready", 32'(bus.req_ready), 32'h3);
        check("par_b0csn", 32'(bus.bank0_csn), 32'h0);
        check("par_b1csn", 32'(bus.bank1_csn), 32'h0);
        check("par_wen", 32'(bus.wen), 32'h1);
        check("par_wdata", bus.sram_wdata, 32'hA5A5_5A5A);
        check("par_addr", {6'h0, bus.sram_addr_bank1, bus.sram_addr_bank0}, {6'h0, 13'h0010, 13'h0010});
        expect_rsp(0, 32'hB000_0010);

        // Same-bank read conflict: grants alternate 0,1,0,1.
        for (int i = 0; i < 4; i++) begin
            drive(2'b11, 2'b00, 14'h0020, 14'h0030, 32'h0, 32'h0, 4'h0, 4'h0, 2'b00);
            check($sformatf("cf%0d_ready", i), 32'(bus.req_ready), (i % 2 == 0) ? 32'h1 : 32'h2);
            check($sformatf("cf%0d_rspv", i), 32'(bus.rsp_valid), (i == 2) ? 32'h2 : 32'h1);
            check($sformatf("cf%0d_addr", i), 32'(bus.sram_addr_bank0), (i % 2 == 0) ? 32'h20 : 32'h30);
            check($sformatf("cf%0d_b1csn", i), 32'(bus.bank1_csn), 32'hF);
            if (i % 2 == 0) expect_rsp(0, 32'hB000_0020);
            else expect_rsp(1, 32'hB000_0030);
        end

        // Double write to different banks: requester 0 first, then requester 1.
        drive(2'b11, 2'b11, 14'h0001, 14'h2001, 32'hDEAD_BEEF, 32'hCAFE_F00D, 4'hF, 4'hF, 2'b00);
        check("dw0_ready", 32'(bus.req_ready), 32'h1);
        check("dw0_wdata", bus.sram_wdata, 32'hDEAD_BEEF);
        check("dw0_csn", {24'h0, bus.bank1_csn, bus.bank0_csn}, 32'hF0);
        check("dw0_wen", 32'(bus.wen), 32'h2);
        drive(2'b10, 2'b11, 14'h0001, 14'h2001, 32'hDEAD_BEEF, 32'hCAFE_F00D, 4'hF, 4'hF, 2'b00);
        check("dw1_ready", 32'(bus.req_ready), 32'h2);
        check("dw1_wdata", bus.sram_wdata, 32'hCAFE_F00D);
        check("dw1_csn", {24'h0, bus.bank1_csn, bus.bank0_csn}, 32'h0F);
        check("dw1_wen", 32'(bus.wen), 32'h1);
        drive(2'b11, 2'b00, 14'h0001, 14'h2001, 32'h0, 32'h0, 4'h0, 4'h0, 2'b00);
        check("dwr_ready", 32'(bus.req_ready), 32'h3);
        expect_rsp(0, 32'hDEAD_BEEF);
        expect_rsp(1, 32'hCAFE_F00D);

        // Partial write over 0xFFFFFFFF, then read-after-write by the other requester.
        drive(2'b01, 2'b01, 14'h0004, 14'h0, 32'hFFFF_FFFF, 32'h0, 4'hF, 4'h0, 2'b00);
        check("pw_fill_ready", 32'(bus.req_ready), 32'h1);
        drive(2'b01, 2'b01, 14'h0004, 14'h0, 32'h1122_3344, 32'h0, 4'h5, 4'h0, 2'b00);
        check("pw_csn", 32'(bus.bank0_csn), 32'hA);
        check("pw_wdata", bus.sram_wdata, 32'h1122_3344);
        drive(2'b10, 2'b00, 14'h0, 14'h0004, 32'h0, 32'h0, 4'h0, 4'h0, 2'b00);
        check("pw_rd_ready", 32'(bus.req_ready), 32'h2);
        check("pw_rd_addr", 32'(bus.sram_addr_bank0), 32'h4);
        expect_rsp(1, 32'hFF22_FF44);

        // Zero-strobe write: granted, no lane selected, data unchanged.
        drive(2'b10, 2'b10, 14'h0, 14'h2005, 32'h0, 32'h1234_5678, 4'h0, 4'h0, 2'b00);
        check("zs_ready", 32'(bus.req_ready), 32'h2);
        check("zs_csn", 32'(bus.bank1_csn), 32'hF);
        check("zs_wen", 32'(bus.wen), 32'h1);
        drive(2'b10, 2'b00, 14'h0, 14'h2005, 32'h0, 32'h0, 4'h0, 4'h0, 2'b00);
        expect_rsp(1, 32'hB100_0005);

        // Reset in the cycle after a read grant: response dropped, pointer back to requester 0.
        drive(2'b01, 2'b00, 14'h0040, 14'h0, 32'h0, 32'h0, 4'h0, 4'h0, 2'b00);
        check("mr_ready", 32'(bus.req_ready), 32'h1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.req_valid = 2'b11; bus.req_wr = 2'b00;
        @(negedge clk);
        check("mr_rspv", 32'(bus.rsp_valid), 32'h0);
        check("mr_rdata0", bus.rsp_rdata0, 32'h0);
        check("mr_csn", {24'h0, bus.bank1_csn, bus.bank0_csn}, 32'hFF);
        check("mr_rst_ready", 32'(bus.req_ready), 32'h0);
        bus.req_valid = 2'b00;
        rst_n = 1'b1;
        drive(2'b11, 2'b00, 14'h2050, 14'h2060, 32'h0, 32'h0, 4'h0, 4'h0, 2'b00);
        check("pr_ready", 32'(bus.req_ready), 32'h1);
        expect_rsp(0, 32'hB100_0050);
        drive(2'b10, 2'b00, 14'h2050, 14'h2060, 32'h0, 32'h0, 4'h0, 4'h0, 2'b00);
        check("pr1_ready", 32'(bus.req_ready), 32'h2);
        expect_rsp(1, 32'hB100_0060);

`ifdef SRAM_ARB_LOCK_EN
        // Requester 1 locks for three bank1 writes; requester 0 waits despite using bank0.
        drive(2'b10, 2'b10, 14'h0, 14'h2070, 32'h0, 32'h0000_0070, 4'h0, 4'hF, 2'b10);
        check("lk0_ready", 32'(bus.req_ready), 32'h2);
        drive(2'b11, 2'b10, 14'h0070, 14'h2071, 32'h0, 32'h0000_0071, 4'h0, 4'hF, 2'b10);
        check("lk1_ready", 32'(bus.req_ready), 32'h2);
        drive(2'b11, 2'b10, 14'h0070, 14'h2072, 32'h0, 32'h0000_0072, 4'h0, 4'hF, 2'b00);
        check("lk2_ready", 32'(bus.req_ready), 32'h2);
        drive(2'b01, 2'b00, 14'h0070, 14'h0, 32'h0, 32'h0, 4'h0, 4'h0, 2'b00);
        check("lk_rel_ready", 32'(bus.req_ready), 32'h1);
        expect_rsp(0, 32'hB000_0070);
        drive(2'b10, 2'b00, 14'h0, 14'h2071, 32'h0, 32'h0, 4'h0, 4'h0, 2'b00);
        check("lk_rd_ready", 32'(bus.req_ready), 32'h2);
        expect_rsp(1, 32'h0000_0071);
`endif

        repeat (3) idle();
        check("q0_drained", 32'(q0.size()), 32'h0);
        check("q1_drained", 32'(q1.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sram_bank_arbiter.md
Name: sram_bank_arbiter

Overview:
- Two-requester arbiter in front of the dual-bank SRAM array: two 32-bit-wide, 8k-deep banks, each built from four byte-lane bist_sram macros.
- Sits between the AXI2MEM read engine (requester 0), the write engine / DMA (requester 1) and the bank strobes (addr, csn, wen, shared wdata).
- Grants both requesters in the same cycle when they target different banks and at most one of them writes; otherwise uses round-robin.
- Returns read data one cycle after grant.

Parameters:
- IDX_W, 13, per-bank word index width (8k words).
- ADDR_W, 14, requester word address width: bit IDX_W selects the bank, bits [IDX_W-1:0] are the index.

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  asynchronous active-low reset
- req_valid  in  2  request valid, one bit per requester (bit n = requester n)
- req_ready  out  2  request granted this cycle
- req_wr  in  2  1 = write, 0 = read
- req_addr0 / req_addr1  in  ADDR_W each  word address
- req_wdata0 / req_wdata1  in  32 each  write data
- req_wstrb0 / req_wstrb1  in  4 each  byte strobes
- req_lock  in  2  exclusive hold request (optional feature only)
- rsp_valid  out  2  read data valid for requester n
- rsp_rdata0 / rsp_rdata1  out  32 each  read data
- sram_addr_bank0 / sram_addr_bank1  out  IDX_W each  bank index
- bank0_csn / bank1_csn  out  4 each  per-lane chip select, active low
- wen  out  2  per-bank write enable, active low (0 = write)
- sram_wdata  out  32  shared write data
- sram0..sram7  in  8 each  lane read data (bank0 = sram0..3, bank1 = sram4..7, LSB lane first)

Behaviour:
- The decision is combinational within the cycle.
- A transfer occurs on req_valid[n] & req_ready[n]. SRAM strobes are driven in that same cycle T.
- Requesters hold valid, addr, wdata and wr stable until ready. The arbiter does not depend on this for correctness.
- Conflict: both valid and either (same bank) or (both writes).
  - On conflict, grant the requester indicated by rr_ptr.
  - rr_ptr then points to the other requester.
  - rr_ptr changes only on a conflict grant.
- No conflict: grant every valid requester; rr_ptr is unchanged.
- Strobes for a granted read: bank csn = 4'b0000, wen[b] = 1.
- Strobes for a granted write: bank csn = ~wstrb, wen[b] = 0, sram_wdata = that requester's wdata.
  - A write with wstrb = 0 is still granted and completes, but no lane is selected.
- Ungranted bank: csn = 4'hF, wen = 1, addr = 0.
- sram_wdata = 0 when no write is granted.
- Read response: a per-requester tag register {pending, bank} is set at T.
  - rsp_valid[n] = 1 at T+1.
  - rsp_rdata = the lane concatenation of the tagged bank, taken from the sram* inputs.
- There is no response backpressure; the requester must accept rsp at T+1.
- Back-to-back reads are allowed: a grant at T+1 coexists with the response from T.
- Write: no response.
- Reset (async, any time):
  - rr_ptr = 0 (requester 0 first); tags cleared.
  - Outputs held at: req_ready = 0, rsp_valid = 0, rsp_rdata = 0, csn = 4'hF, wen = 2'b11, addrs = 0, sram_wdata = 0.
  - An in-flight read response is dropped.
  - After reset deassertion, the first grant is possible in the first cycle.
- Read-after-write to the same word by different requesters in consecutive cycles: the read returns the new data. This is a property of the bank's write-then-read ordering, not of the arbiter.

Optional Feature:
- Macro: SRAM_ARB_LOCK_EN.
- Defined:
  - A requester granted while req_lock[n] = 1 takes lock_owner.
  - While locked, the other requester gets req_ready = 0 regardless of bank.
  - The owner is granted whenever valid.
  - The lock releases on the first owner grant with req_lock[n] = 0, or when the owner drops req_valid with req_lock = 0.
  - rr_ptr is frozen while locked.
  - Reset clears the lock.
- Undefined: req_lock is ignored and no lock state exists.

Test Plan:
- Parallel grant: req0 read 0x0010 (bank0) and req1 write 0x2010 (bank1), data 0xA5A5_5A5A, strb 0xF, same cycle.
  - Expect ready = 2'b11, bank0_csn = 0, wen = 2'b01.
  - Expect rsp_valid = 2'b01 next cycle.
- Same-bank conflict: both read bank0 continuously for 4 cycles.
  - Expect grants 0, 1, 0, 1 (rr_ptr alternates).
  - Expect each response one cycle after its grant.
- Double write to different banks: write 0x0001 and 0x2001 together.
  - Expect only requester 0 granted first, requester 1 the next cycle.
  - Expect sram_wdata to match each granted requester.
- Partial write: write 0x11223344 strb 0x5 to 0x0004 over existing 0xFFFFFFFF, then read it.
  - Expect bank0_csn = 4'b1010 during the write.
  - Expect readback 0xFF22FF44.
- Reset mid-read: assert ARESETn = 0 in the cycle after a read grant.
  - Expect rsp_valid = 0 and all csn = 4'hF immediately.
  - Expect the first post-reset conflict granted to requester 0.
- SRAM_ARB_LOCK_EN: requester 1 locks, then 3 writes to bank1 while requester 0 reads bank0.
  - Expect req_ready[0] = 0 throughout.
  - Expect requester 0 granted the cycle after the lock releases.
